// File: rtl/neuron_mac.sv
// Single-neuron MAC: signed multiply, saturating accumulate over numInputs pairs, saturating bias add.
// Latency 3 cycles from the last accepted pair to sum_valid; no backpressure, one pair accepted per cycle.
module neuron_mac #(
   parameter int dataWidth = 16,
   parameter int numInputs = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [dataWidth-1:0]     x_in,
   input  logic [dataWidth-1:0]     w_in,
   input  logic                     x_valid,
   input  logic [2*dataWidth-1:0]   bias,
   output logic [2*dataWidth-1:0]   sum,
   output logic                     sum_valid
);
   localparam int PW = 2 * dataWidth;
   localparam int CW = $clog2(numInputs) + 1;
   localparam logic [CW-1:0] LAST = CW'(numInputs - 1);
   localparam logic [PW-1:0] MAX_POS = {1'b0, {(PW-1){1'b1}}};
   localparam logic [PW-1:0] MAX_NEG = {1'b1, {(PW-1){1'b0}}};

   // Clamp only when both operands share a sign and the wrapped result flips it.
   function automatic logic [PW-1:0] satadd(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [PW-1:0] s;
      s = a + b;
      if ((a[PW-1] == b[PW-1]) && (s[PW-1] != a[PW-1]))
         s = a[PW-1] ? MAX_NEG : MAX_POS;
      return s;
   endfunction

   logic signed [PW-1:0] w_prod;
   logic [PW-1:0]        w_acc_nxt;
   logic                 w_last;

   logic [PW-1:0]        r_mul;
   logic                 r_mul_v;
   logic [PW-1:0]        r_acc;
   logic [CW-1:0]        r_cnt;
   logic [PW-1:0]        r_fin;
   logic                 r_fin_v;
   logic [PW-1:0]        r_sum;
   logic                 r_sum_valid;

   assign w_prod    = PW'($signed(x_in)) * PW'($signed(w_in));
   assign w_acc_nxt = satadd(r_acc, r_mul);
   assign w_last    = (r_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul   <= '0;
         r_mul_v <= 1'b0;
      end else begin
         r_mul_v <= x_valid;
         if (x_valid)
            r_mul <= w_prod;
      end
   end

   // The last product goes straight to r_fin so the next vector starts from zero with no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_fin   <= '0;
         r_fin_v <= 1'b0;
      end else if (r_mul_v) begin
         if (w_last) begin
            r_fin   <= w_acc_nxt;
            r_fin_v <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
         end else begin
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + 1'b1;
            r_fin_v <= 1'b0;
         end
      end else begin
         r_fin_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum       <= '0;
         r_sum_valid <= 1'b0;
      end else begin
         r_sum_valid <= r_fin_v;
         if (r_fin_v)
            r_sum <= satadd(r_fin, bias);
      end
   end

   assign sum       = r_sum;
   assign sum_valid = r_sum_valid;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed vector table, randomized streaming against an arithmetic model, reset mid-vector.
module tb_neuron_mac;
   localparam int DW = 16;
   localparam int NI = 4;
   localparam int PW = 2 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] x_in;
   logic [DW-1:0] w_in;
   logic          x_valid;
   logic [PW-1:0] bias;
   logic [PW-1:0] sum;
   logic          sum_valid;

   always #5 clk = ~clk;

   neuron_mac #(.dataWidth(DW), .numInputs(NI)) dut (
      .clk(clk), .rst(rst), .x_in(x_in), .w_in(w_in), .x_valid(x_valid),
      .bias(bias), .sum(sum), .sum_valid(sum_valid)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [PW-1:0] mon_sum[$];
   int            mon_cyc[$];
   always @(negedge clk) begin
      if (!rst && sum_valid) begin
         mon_sum.push_back(sum);
         mon_cyc.push_back(cyc);
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      string                  nm;
      logic [NI-1:0][DW-1:0]  x;
      logic [NI-1:0][DW-1:0]  w;
      logic [PW-1:0]          b;
      logic [PW-1:0]          exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input string nm, input int x0, input int x1, input int x2, input int x3,
                          input int w0, input int w1, input int w2, input int w3,
                          input int b, input logic [PW-1:0] exp);
      vec_t v;
      v.nm = nm;
      v.x[0] = DW'(x0); v.x[1] = DW'(x1); v.x[2] = DW'(x2); v.x[3] = DW'(x3);
      v.w[0] = DW'(w0); v.w[1] = DW'(w1); v.w[2] = DW'(w2); v.w[3] = DW'(w3);
      v.b = PW'(b);
      v.exp = exp;
      tbl.push_back(v);
   endtask

   // Reference: true integer sum clamped to the PW-bit signed range after every addition.
   function automatic longint clamp(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic logic [PW-1:0] model(input logic [NI-1:0][DW-1:0] xs,
                                           input logic [NI-1:0][DW-1:0] ws,
                                           input logic [PW-1:0] b);
      longint a = 0;
      for (int i = 0; i < NI; i++)
         a = clamp(a + longint'($signed(xs[i])) * longint'($signed(ws[i])));
      a = clamp(a + longint'($signed(b)));
      return a[PW-1:0];
   endfunction

   task automatic drive_pair(input logic [DW-1:0] xv, input logic [DW-1:0] wv, output int at);
      @(negedge clk);
      x_in = xv; w_in = wv; x_valid = 1'b1;
      at = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         x_valid = 1'b0;
         x_in = DW'($urandom);
         w_in = DW'($urandom);
      end
   endtask

   task automatic wait_pulse(input string nm, output logic found, output logic [PW-1:0] s, output int c);
      found = 1'b0; s = '0; c = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk); #1;
         if (mon_sum.size() > 0) begin
            found = 1'b1;
            s = mon_sum.pop_front();
            c = mon_cyc.pop_front();
         end
      end
      if (!found) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: got no sum_valid, expected one within 12 cycles", nm);
      end
   endtask

   function automatic logic [DW-1:0] rnd_dat();
      case ($urandom_range(0, 3))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         default: return DW'($urandom);
      endcase
   endfunction

   initial begin
      logic          found;
      logic [PW-1:0] s;
      int            c, at;

      add_vec("basic",     1, 2, 3, 4,          1, 1, 1, 1,               10, 32'h0000_0014);
      add_vec("neg",      -5,-5,-5,-5,          3, 3, 3, 3,                0, 32'hFFFF_FFC4);
      add_vec("neg_bias", -5,-5,-5,-5,          3, 3, 3, 3,              100, 32'h0000_0028);
      add_vec("pos_sat",  -32768,-32768,-32768,-32768, -32768,-32768,-32768,-32768, 5, 32'h7FFF_FFFF);
      add_vec("nonsticky",-32768,-32768,-32768,-32768, -32768,-32768,32767,32767,  0, 32'h0000_FFFF);
      add_vec("neg_sat",  -32768,-32768,-32768,-32768, 32767,32767,32767,32767,   -1, 32'h8000_0000);

      rst = 1'b1; x_valid = 1'b0; x_in = '0; w_in = '0; bias = '0;
      @(posedge clk); #1;
      chk("reset_sum", sum, '0);
      chk("reset_valid", PW'(sum_valid), '0);
      @(negedge clk); #2 rst = 1'b0;

      foreach (tbl[k]) begin
         bias = tbl[k].b;
         for (int i = 0; i < NI; i++) drive_pair(tbl[k].x[i], tbl[k].w[i], at);
         idle(1);
         wait_pulse(tbl[k].nm, found, s, c);
         if (found) begin
            chk(tbl[k].nm, s, tbl[k].exp);
            chk({tbl[k].nm, "_lat"}, PW'(c - at), PW'(3));
         end
         idle(4);
         chk({tbl[k].nm, "_hold"}, sum, tbl[k].exp);
         chk({tbl[k].nm, "_pulses"}, PW'(mon_sum.size()), '0);
      end

      for (int r = 0; r < 5; r++) begin
         logic [NI-1:0][DW-1:0] xs[3];
         logic [NI-1:0][DW-1:0] ws[3];
         logic [PW-1:0]         expv[3];
         int                    cs[3];
         bias = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : PW'($urandom);
         for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < NI; i++) begin xs[v][i] = rnd_dat(); ws[v][i] = rnd_dat(); end
            expv[v] = model(xs[v], ws[v], bias);
         end
         for (int v = 0; v < 3; v++)
            for (int i = 0; i < NI; i++) begin
               if (v == 2 && i > 0) idle($urandom_range(1, 3));
               drive_pair(xs[v][i], ws[v][i], at);
            end
         idle(10);
         chk($sformatf("stream%0d_pulses", r), PW'(mon_sum.size()), PW'(3));
         for (int v = 0; v < 3; v++) begin
            s = '0; cs[v] = 0;
            if (mon_sum.size() > 0) begin s = mon_sum.pop_front(); cs[v] = mon_cyc.pop_front(); end
            chk($sformatf("stream%0d_v%0d", r, v), s, expv[v]);
         end
         chk($sformatf("stream%0d_b2b_gap", r), PW'(cs[1] - cs[0]), PW'(NI));
         mon_sum.delete(); mon_cyc.delete();
      end

      bias = '0;
      drive_pair(16'd100, 16'd100, at);
      drive_pair(16'd100, 16'd100, at);
      @(negedge clk); x_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_async_sum", sum, '0);
      chk("rst_async_valid", PW'(sum_valid), '0);
      @(posedge clk); #1;
      chk("rst_held_sum", sum, '0);
      @(negedge clk); #2 rst = 1'b0;
      for (int i = 0; i < NI; i++) drive_pair(16'd1, 16'd2, at);
      idle(1);
      wait_pulse("rst_recover", found, s, c);
      if (found) begin
         chk("rst_recover", s, PW'(8));
         chk("rst_recover_lat", PW'(c - at), PW'(3));
      end
      idle(8);
      chk("rst_recover_pulses", PW'(mon_sum.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, expected finish before 200000");
      $fatal(1);
   end
endmodule
